// File: rtl/alu_seq_if.sv
// Bundle between the instruction decoder, the alu_seq issue/writeback sequencer and the ALU.
// The decoder side is the master; the sequencer side is the slave.
interface alu_seq_if #(
  parameter int W  = 8,
  parameter int CW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_op;
  logic          in_src;
  logic [W-1:0]  in_k;
  logic          x_we;
  logic [W-1:0]  x_wdata;
  logic          err_clr;
  logic [W-1:0]  alu_i1;
  logic [W-1:0]  alu_i2;
  logic [3:0]    alu_op;
  logic [W-1:0]  alu_o;
  logic [W-1:0]  acc;
  logic [W-1:0]  x;
  logic          done;
  logic          err;
  logic [CW-1:0] retired;

  modport master (
    output in_valid, in_op, in_src, in_k, x_we, x_wdata, err_clr, alu_o,
    input  in_ready, alu_i1, alu_i2, alu_op, acc, x, done, err, retired
  );

  modport slave (
    input  in_valid, in_op, in_src, in_k, x_we, x_wdata, err_clr, alu_o,
    output in_ready, alu_i1, alu_i2, alu_op, acc, x, done, err, retired
  );
endinterface

// File: rtl/alu_seq.sv
// Issue/writeback sequencer: accepts one accumulator instruction, drives the ALU for one
// cycle, writes the result back to A and reports done, sticky errors and a retired count.
module alu_seq #(
  parameter int W  = 8,
  parameter int CW = 16
) (
  input  logic      clk,
  input  logic      rst,
  alu_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  x_q, x_d;
  logic [W-1:0]  i1_q, i1_d;
  logic [W-1:0]  i2_q, i2_d;
  logic [3:0]    op_q, op_d;
  logic          err_q, err_d;
  logic [CW-1:0] ret_q, ret_d;

  logic accept;
  logic illegal;

  assign accept  = (state_q == IDLE) && bus.in_valid;
  // The ALU bus registers double as the latched instruction while in EXEC.
  assign illegal = op_q[3] || ((op_q == 4'd4) && (i2_q == '0));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    x_d     = x_q;
    i1_d    = i1_q;
    i2_d    = i2_q;
    op_d    = op_q;
    err_d   = err_q;
    ret_d   = ret_q;

    if (bus.x_we) begin
      x_d = bus.x_wdata;
    end
    if (bus.err_clr) begin
      err_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          i1_d    = a_q;
          i2_d    = bus.in_src ? x_q : bus.in_k;
          op_d    = bus.in_op;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // A new error overrides a coincident err_clr.
        if (illegal) begin
          err_d = 1'b1;
        end else begin
          a_d = bus.alu_o;
        end
        i1_d    = '0;
        i2_d    = '0;
        op_d    = '0;
        ret_d   = ret_q + CW'(1);
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      x_q     <= '0;
      i1_q    <= '0;
      i2_q    <= '0;
      op_q    <= '0;
      err_q   <= 1'b0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      x_q     <= x_d;
      i1_q    <= i1_d;
      i2_q    <= i2_d;
      op_q    <= op_d;
      err_q   <= err_d;
      ret_q   <= ret_d;
    end
  end

  assign bus.in_ready = (state_q == IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.alu_i1   = i1_q;
  assign bus.alu_i2   = i2_q;
  assign bus.alu_op   = op_q;
  assign bus.acc      = a_q;
  assign bus.x        = x_q;
  assign bus.err      = err_q;
  assign bus.retired  = ret_q;

endmodule
